// File: rtl/sdram_para.sv
// Shared constants for the SDRAM auto-refresh stage.
// Holds the command encodings driven as {cs_n,ras_n,cas_n,we_n}, the
// precharge-all address (A10=1), the refresh FSM state encoding and a
// counter-width helper.
package sdram_para;

  localparam logic [3:0]  CMD_NOP      = 4'b0111;
  localparam logic [3:0]  CMD_PREGE    = 4'b0010;
  localparam logic [3:0]  CMD_A_REF    = 4'b0001;
  localparam logic [3:0]  CMD_MRS      = 4'b0000;
  localparam logic [11:0] ADDR_PRE_ALL = 12'b0100_0000_0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_GNT,
    ST_PRE,
    ST_TRP,
    ST_AREF,
    ST_TRFC
  } aref_state_t;

  // Bits needed to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sdram_aref_timer.sv
// Refresh period timer: free-running 0..REF_PERIOD-1 counter while init_end
// is high, plus the sticky refresh request and the missed-period pulse.
// Ports:
//   clk, rst    clock / asynchronous active-high reset
//   init_end    counting enable; low clears counter and request
//   grant_take  arbiter grant accepted by the FSM this cycle
//   aref_req    sticky request, cleared by grant_take
//   aref_miss   one-cycle pulse when a wrap finds the request still pending
module sdram_aref_timer
  import sdram_para::*;
#(
  parameter int unsigned REF_PERIOD = 780
) (
  input  logic clk,
  input  logic rst,
  input  logic init_end,
  input  logic grant_take,
  output logic aref_req,
  output logic aref_miss
);

  localparam int unsigned     CNT_W   = cnt_w(REF_PERIOD);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REF_PERIOD - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_req;
  logic             r_miss;
  logic             r_pend;
  logic             w_wrap;

  assign w_wrap = init_end && (r_cnt == CNT_MAX);

  // A wrap colliding with a grant is parked in r_pend and re-raises the
  // request one cycle later instead of being dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_req  <= 1'b0;
      r_miss <= 1'b0;
      r_pend <= 1'b0;
    end else if (!init_end) begin
      r_cnt  <= '0;
      r_req  <= 1'b0;
      r_miss <= 1'b0;
      r_pend <= 1'b0;
    end else begin
      r_cnt  <= w_wrap ? '0 : r_cnt + CNT_W'(1);
      r_miss <= w_wrap && r_req && !grant_take;
      if (grant_take) begin
        r_req  <= 1'b0;
        r_pend <= w_wrap;
      end else begin
        r_req  <= r_req | w_wrap | r_pend;
        r_pend <= 1'b0;
      end
    end
  end

  assign aref_req  = r_req;
  assign aref_miss = r_miss;

endmodule

// File: rtl/sdram_aref.sv
// SDRAM periodic auto-refresh stage. After init_end, requests a refresh every
// REF_PERIOD clocks, and on grant issues PRECHARGE-ALL, waits tRP, issues
// AUTO REFRESH, waits tRFC and pulses aref_end.
// Build option: define SDRAM_AREF_DOUBLE_EN to issue two AUTO REFRESH
// commands (each followed by tRFC) per grant.
// Ports:
//   clk, rst    clock / asynchronous active-high reset
//   init_end    power-up init complete (level)
//   aref_en     arbiter grant
//   aref_req    refresh request to arbiter
//   aref_cmd    {cs_n,ras_n,cas_n,we_n}, registered
//   aref_addr   precharge-all address (A10=1)
//   aref_end    one-cycle pulse on the last cycle of the sequence
//   aref_miss   one-cycle pulse when a period elapsed with a request pending
module sdram_aref
  import sdram_para::*;
#(
  parameter int unsigned REF_PERIOD = 780,
  parameter int unsigned TRP_CYC    = 2,
  parameter int unsigned TRFC_CYC   = 4,
  parameter int unsigned ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_end,
  input  logic                  aref_en,
  output logic                  aref_req,
  output logic [3:0]            aref_cmd,
  output logic [ADDR_WIDTH-1:0] aref_addr,
  output logic                  aref_end,
  output logic                  aref_miss
);

  localparam int unsigned WAIT_MAX = (TRP_CYC > TRFC_CYC) ? TRP_CYC : TRFC_CYC;
  localparam int unsigned WAIT_W   = cnt_w(WAIT_MAX);

  aref_state_t       r_state, w_state_nxt;
  logic [WAIT_W-1:0] r_wait,  w_wait_nxt;
  logic [3:0]        r_cmd,   w_cmd_nxt;
  logic              r_end,   w_end_nxt;
  logic              w_grant;
`ifdef SDRAM_AREF_DOUBLE_EN
  logic              r_pass,  w_pass_nxt;
`endif

  assign w_grant = (r_state == ST_WAIT_GNT) && aref_en && aref_req;

  sdram_aref_timer #(
    .REF_PERIOD (REF_PERIOD)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .init_end   (init_end),
    .grant_take (w_grant),
    .aref_req   (aref_req),
    .aref_miss  (aref_miss)
  );

  // State and registered command/end outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_wait  <= '0;
      r_cmd   <= CMD_NOP;
      r_end   <= 1'b0;
`ifdef SDRAM_AREF_DOUBLE_EN
      r_pass  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_wait  <= w_wait_nxt;
      r_cmd   <= w_cmd_nxt;
      r_end   <= w_end_nxt;
`ifdef SDRAM_AREF_DOUBLE_EN
      r_pass  <= w_pass_nxt;
`endif
    end
  end

  // Next state; outputs decode the state being entered so they line up with it.
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait;
    w_cmd_nxt   = CMD_NOP;
    w_end_nxt   = 1'b0;
`ifdef SDRAM_AREF_DOUBLE_EN
    w_pass_nxt  = r_pass;
`endif
    unique case (r_state)
      ST_IDLE: begin
        if (aref_req) w_state_nxt = ST_WAIT_GNT;
      end
      ST_WAIT_GNT: begin
        if (w_grant) begin
          w_state_nxt = ST_PRE;
`ifdef SDRAM_AREF_DOUBLE_EN
          w_pass_nxt  = 1'b0;
`endif
        end else if (!aref_req) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_PRE: begin
        w_state_nxt = ST_TRP;
        w_wait_nxt  = '0;
      end
      ST_TRP: begin
        if (r_wait == WAIT_W'(TRP_CYC - 1)) w_state_nxt = ST_AREF;
        else                                w_wait_nxt  = r_wait + WAIT_W'(1);
      end
      ST_AREF: begin
        w_state_nxt = ST_TRFC;
        w_wait_nxt  = '0;
      end
      ST_TRFC: begin
        if (r_wait == WAIT_W'(TRFC_CYC - 1)) begin
`ifdef SDRAM_AREF_DOUBLE_EN
          if (!r_pass) begin
            w_state_nxt = ST_AREF;
            w_pass_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
`else
          w_state_nxt = ST_IDLE;
`endif
        end else begin
          w_wait_nxt = r_wait + WAIT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_state_nxt == ST_PRE)  w_cmd_nxt = CMD_PREGE;
    if (w_state_nxt == ST_AREF) w_cmd_nxt = CMD_A_REF;

    // End pulse rides on the final tRFC cycle of the final pass.
    if ((w_state_nxt == ST_TRFC) && (w_wait_nxt == WAIT_W'(TRFC_CYC - 1))) begin
`ifdef SDRAM_AREF_DOUBLE_EN
      w_end_nxt = w_pass_nxt;
`else
      w_end_nxt = 1'b1;
`endif
    end
  end

  assign aref_cmd  = r_cmd;
  assign aref_end  = r_end;
  assign aref_addr = ADDR_WIDTH'(ADDR_PRE_ALL);

endmodule

// File: tb/tb_sdram_aref.sv
// Scoreboard bench for sdram_aref: a cycle-level reference model pushes the
// expected outputs for every clock, a monitor pops and compares them.
module tb_sdram_aref;

  localparam int unsigned P    = 100;
  localparam int unsigned TRP  = 2;
  localparam int unsigned TRFC = 4;
  localparam int unsigned AW   = 12;
`ifdef SDRAM_AREF_DOUBLE_EN
  localparam int unsigned PASSES = 2;
`else
  localparam int unsigned PASSES = 1;
`endif
  localparam int unsigned SEQ_LEN = 1 + TRP + PASSES * (1 + TRFC);

  localparam logic [3:0] C_NOP  = 4'b0111;
  localparam logic [3:0] C_PRE  = 4'b0010;
  localparam logic [3:0] C_AREF = 4'b0001;

  logic          clk      = 1'b0;
  logic          rst      = 1'b1;
  logic          init_end = 1'b0;
  logic          aref_en  = 1'b0;
  logic          aref_req;
  logic [3:0]    aref_cmd;
  logic [AW-1:0] aref_addr;
  logic          aref_end;
  logic          aref_miss;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       req;
    logic [3:0] cmd;
    logic       endp;
    logic       miss;
  } exp_t;

  exp_t       exp_q[$];
  logic [4:0] m_sched[$];   // future {end, cmd} per cycle of a granted sequence
  int         m_tick  = 0;
  bit         m_req   = 0;
  bit         m_pend  = 0;
  bit         m_armed = 0;
  bit         m_busy  = 0;

  always #10 clk = ~clk;

  sdram_aref #(
    .REF_PERIOD (P),
    .TRP_CYC    (TRP),
    .TRFC_CYC   (TRFC),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .init_end  (init_end),
    .aref_en   (aref_en),
    .aref_req  (aref_req),
    .aref_cmd  (aref_cmd),
    .aref_addr (aref_addr),
    .aref_end  (aref_end),
    .aref_miss (aref_miss)
  );

  // Command script for one granted refresh.
  function automatic void push_refresh();
    m_sched.push_back({1'b0, C_PRE});
    for (int i = 0; i < int'(TRP); i++) m_sched.push_back({1'b0, C_NOP});
    for (int p = 0; p < int'(PASSES); p++) begin
      m_sched.push_back({1'b0, C_AREF});
      for (int i = 0; i < int'(TRFC); i++)
        m_sched.push_back({(p == int'(PASSES) - 1) && (i == int'(TRFC) - 1), C_NOP});
    end
  endfunction

  // Reference model: expected outputs for the cycle following each edge.
  always @(posedge clk) begin : model
    bit grant, wrap, nreq, npend, nmiss, busy_n, armed_n;
    logic [4:0] s;
    exp_t e;
    if (rst) begin
      m_tick = 0; m_req = 0; m_pend = 0; m_armed = 0; m_busy = 0;
      m_sched.delete();
      e.req = 1'b0; e.cmd = C_NOP; e.endp = 1'b0; e.miss = 1'b0;
    end else begin
      grant = m_armed && aref_en && m_req;
      wrap  = init_end && (m_tick == int'(P) - 1);
      nmiss = 0; npend = 0; nreq = 0;
      if (!init_end) begin
        m_tick = 0;
      end else begin
        m_tick = (m_tick + 1) % int'(P);
        nmiss  = wrap && m_req && !grant;
        if (grant) npend = wrap;
        else       nreq  = m_req || wrap || m_pend;
      end
      busy_n = 0; armed_n = 0;
      if (m_busy)       busy_n = (m_sched.size() != 0);
      else if (grant) begin
        push_refresh();
        busy_n = 1;
      end else          armed_n = m_req;
      e.req = nreq; e.miss = nmiss; e.cmd = C_NOP; e.endp = 1'b0;
      if (busy_n) begin
        s = m_sched.pop_front();
        e.endp = s[4];
        e.cmd  = s[3:0];
      end
      m_req = nreq; m_pend = npend; m_busy = busy_n; m_armed = armed_n;
    end
    exp_q.push_back(e);
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin : monitor
    exp_t e;
    #2;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty at %0t: got 0 entries expected 1", $time);
    end else begin
      e = exp_q.pop_front();
      chk("aref_req",  16'(aref_req),  16'(e.req));
      chk("aref_cmd",  16'(aref_cmd),  16'(e.cmd));
      chk("aref_end",  16'(aref_end),  16'(e.endp));
      chk("aref_miss", 16'(aref_miss), 16'(e.miss));
      chk("aref_addr", 16'(aref_addr), 16'h0400);
    end
  end

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout at %0t: got no event expected one", name, $time);
  endtask

  initial begin
    bit found;
    int mode;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle with init low.
    repeat (500) begin
      @(negedge clk);
      aref_en = 1'($urandom_range(0, 1));
    end

    // Basic refresh with grant held high.
    init_end = 1'b1;
    aref_en  = 1'b1;
    repeat (2 * P + 40) @(negedge clk);

    // Delayed grant: misses accumulate, one sequence afterwards.
    aref_en = 1'b0;
    repeat (320) @(negedge clk);
    aref_en = 1'b1;
    repeat (30) @(negedge clk);

    // Grant on the exact wrap edge.
    aref_en = 1'b0;
    found = 0;
    for (int i = 0; i < 3 * int'(P) && !found; i++) begin
      @(negedge clk);
      if (m_tick == int'(P) - 1 && m_armed) found = 1;
    end
    if (!found) timeout("collision_wait");
    aref_en = 1'b1;
    repeat (20) @(negedge clk);

    // Reset in the tRP window.
    found = 0;
    for (int i = 0; i < 3 * int'(P) && !found; i++) begin
      @(negedge clk);
      if (m_busy && m_sched.size() == SEQ_LEN - 2) found = 1;
    end
    if (!found) timeout("trp_wait");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (P + 20) @(negedge clk);

    // init_end drops mid-sequence.
    found = 0;
    for (int i = 0; i < 3 * int'(P) && !found; i++) begin
      @(negedge clk);
      if (m_busy && m_sched.size() == SEQ_LEN - 4) found = 1;
    end
    if (!found) timeout("busy_wait");
    init_end = 1'b0;
    repeat (20) @(negedge clk);
    init_end = 1'b1;

    // Randomized segments.
    for (int seg = 0; seg < 40; seg++) begin
      mode = int'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
      if ($urandom_range(0, 14) == 0) begin
        init_end = 1'b0;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        init_end = 1'b1;
      end
      for (int c = 0; c < 60; c++) begin
        case (mode)
          0:       aref_en = 1'b1;
          1:       aref_en = 1'b0;
          default: aref_en = 1'($urandom_range(0, 1));
        endcase
        @(negedge clk);
      end
    end

    aref_en = 1'b0;
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
